// File: rtl/io_dev_decoder.sv
// I/O device decoder: turns the bridge's FD0xxxxx master bus into one-hot device selects,
// returns device ack/data and ends accesses to unmapped or silent devices with an error ack.
module io_dev_decoder #(
    parameter int         NDEV    = 8,
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 s_cyc_i,
    input  logic                 s_stb_i,
    input  logic                 s_we_i,
    input  logic [3:0]           s_sel_i,
    input  logic [31:0]          s_adr_i,
    input  logic [31:0]          s_dat_i,
    output logic                 s_ack_o,
    output logic                 s_err_o,
    output logic [31:0]          s_dat_o,
    output logic [NDEV-1:0]      m_cs_o,
    output logic                 m_cyc_o,
    output logic                 m_stb_o,
    output logic                 m_we_o,
    output logic [3:0]           m_sel_o,
    output logic [15:0]          m_adr_o,
    output logic [31:0]          m_dat_o,
    input  logic [NDEV-1:0]      m_ack_i,
    input  logic [32*NDEV-1:0]   m_dat_i,
    output logic [7:0]           err_cnt_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [3:0] NDEV_W = 4'(NDEV);

    state_t            state_q, state_d;
    logic [2:0]        dev_q, dev_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              ack_d, err_d;
    logic [31:0]       sdat_d;
    logic [NDEV-1:0]   cs_d;
    logic              cyc_d, stb_d, we_d;
    logic [3:0]        sel_d;
    logic [15:0]       adr_d;
    logic [31:0]       mdat_d;
    logic [7:0]        err_cnt_d;

    logic              unmapped;
    logic              dev_ack;
    logic [31:0]       dev_dat;
    logic [7:0]        err_cnt_inc;
    logic              unused_adr;

    // Bridge already fixed the window bits; they carry no decode information here.
    assign unused_adr = ^s_adr_i[31:20];

    assign unmapped    = s_adr_i[19] || ({1'b0, s_adr_i[18:16]} >= NDEV_W);
    assign err_cnt_inc = (err_cnt_o == 8'hFF) ? err_cnt_o : err_cnt_o + 8'd1;

    // Only the latched slot's ack and data are ever looked at.
    always_comb begin
        dev_ack = 1'b0;
        dev_dat = '0;
        for (int k = 0; k < NDEV; k++) begin
            if (dev_q == 3'(k)) begin
                dev_ack = m_ack_i[k];
                dev_dat = m_dat_i[32*k +: 32];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        dev_d     = dev_q;
        cnt_d     = cnt_q;
        ack_d     = s_ack_o;
        err_d     = s_err_o;
        sdat_d    = s_dat_o;
        cs_d      = m_cs_o;
        cyc_d     = m_cyc_o;
        stb_d     = m_stb_o;
        we_d      = m_we_o;
        sel_d     = m_sel_o;
        adr_d     = m_adr_o;
        mdat_d    = m_dat_o;
        err_cnt_d = err_cnt_o;

        case (state_q)
            IDLE: begin
                cs_d = '0;
                if (s_cyc_i && s_stb_i && !s_ack_o) begin
                    if (unmapped) begin
                        ack_d     = 1'b1;
                        err_d     = 1'b1;
                        sdat_d    = 32'hFFFF_FFFF;
                        err_cnt_d = err_cnt_inc;
                        state_d   = RESP;
                    end else begin
                        dev_d = s_adr_i[18:16];
                        for (int k = 0; k < NDEV; k++)
                            cs_d[k] = (s_adr_i[18:16] == 3'(k));
                        cyc_d   = 1'b1;
                        stb_d   = 1'b1;
                        we_d    = s_we_i;
                        sel_d   = s_sel_i;
                        adr_d   = s_adr_i[15:0];
                        mdat_d  = s_dat_i;
                        cnt_d   = 8'd0;
                        state_d = ACCESS;
                    end
                end
            end

            ACCESS: begin
                if (dev_ack) begin
                    sdat_d  = dev_dat;
                    ack_d   = 1'b1;
                    err_d   = 1'b0;
                    cs_d    = '0;
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    we_d    = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == TIMEOUT) begin
                    sdat_d    = 32'hFFFF_FFFF;
                    ack_d     = 1'b1;
                    err_d     = 1'b1;
                    err_cnt_d = err_cnt_inc;
                    cs_d      = '0;
                    cyc_d     = 1'b0;
                    stb_d     = 1'b0;
                    we_d      = 1'b0;
                    state_d   = RESP;
                end else if (!s_cyc_i) begin
                    cs_d    = '0;
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    we_d    = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            RESP: begin
                if (!s_stb_i) begin
                    ack_d   = 1'b0;
                    err_d   = 1'b0;
                    sdat_d  = '0;
                    state_d = IDLE;
                end
            end

            default: begin
                cs_d    = '0;
                cyc_d   = 1'b0;
                stb_d   = 1'b0;
                we_d    = 1'b0;
                ack_d   = 1'b0;
                err_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            dev_q     <= '0;
            cnt_q     <= '0;
            s_ack_o   <= 1'b0;
            s_err_o   <= 1'b0;
            s_dat_o   <= '0;
            m_cs_o    <= '0;
            m_cyc_o   <= 1'b0;
            m_stb_o   <= 1'b0;
            m_we_o    <= 1'b0;
            m_sel_o   <= '0;
            m_adr_o   <= '0;
            m_dat_o   <= '0;
            err_cnt_o <= '0;
        end else begin
            state_q   <= state_d;
            dev_q     <= dev_d;
            cnt_q     <= cnt_d;
            s_ack_o   <= ack_d;
            s_err_o   <= err_d;
            s_dat_o   <= sdat_d;
            m_cs_o    <= cs_d;
            m_cyc_o   <= cyc_d;
            m_stb_o   <= stb_d;
            m_we_o    <= we_d;
            m_sel_o   <= sel_d;
            m_adr_o   <= adr_d;
            m_dat_o   <= mdat_d;
            err_cnt_o <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_io_dev_decoder.sv
// Directed bench for io_dev_decoder with TIMEOUT=4 and eight device slots.
module tb_io_dev_decoder;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         s_cyc_i = 1'b0, s_stb_i = 1'b0, s_we_i = 1'b0;
    logic [3:0]   s_sel_i = '0;
    logic [31:0]  s_adr_i = '0, s_dat_i = '0;
    logic         s_ack_o, s_err_o;
    logic [31:0]  s_dat_o;
    logic [7:0]   m_cs_o;
    logic         m_cyc_o, m_stb_o, m_we_o;
    logic [3:0]   m_sel_o;
    logic [15:0]  m_adr_o;
    logic [31:0]  m_dat_o;
    logic [7:0]   m_ack_i = '0;
    logic [255:0] m_dat_i = '0;
    logic [7:0]   err_cnt_o;

    int n_checks = 0;
    int n_errors = 0;

    io_dev_decoder #(.NDEV(8), .TIMEOUT(8'd4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .s_cyc_i(s_cyc_i), .s_stb_i(s_stb_i), .s_we_i(s_we_i), .s_sel_i(s_sel_i),
        .s_adr_i(s_adr_i), .s_dat_i(s_dat_i),
        .s_ack_o(s_ack_o), .s_err_o(s_err_o), .s_dat_o(s_dat_o),
        .m_cs_o(m_cs_o), .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o),
        .m_sel_o(m_sel_o), .m_adr_o(m_adr_o), .m_dat_o(m_dat_o),
        .m_ack_i(m_ack_i), .m_dat_i(m_dat_i), .err_cnt_o(err_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic req(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                       input logic [31:0] dat);
        s_adr_i = adr; s_we_i = we; s_sel_i = sel; s_dat_i = dat;
        s_cyc_i = 1'b1; s_stb_i = 1'b1;
    endtask

    task automatic drop();
        s_cyc_i = 1'b0; s_stb_i = 1'b0;
    endtask

    initial begin
        // reset state
        #3;
        chk("rst_ack", 32'(s_ack_o), 32'd0);
        chk("rst_cs", 32'(m_cs_o), 32'd0);
        chk("rst_stb", 32'(m_stb_o), 32'd0);
        chk("rst_errcnt", 32'(err_cnt_o), 32'd0);
        tick();
        rst_i = 1'b0;
        tick();

        // read slot 3, device acks two cycles after cs
        req(32'hFD03_0010, 1'b0, 4'hF, 32'h0);
        tick();
        chk("rd_cs", 32'(m_cs_o), 32'h08);
        chk("rd_stb", 32'(m_stb_o), 32'd1);
        chk("rd_adr", 32'(m_adr_o), 32'h0010);
        chk("rd_noack", 32'(s_ack_o), 32'd0);
        tick();
        m_ack_i = 8'h08;
        m_dat_i[3*32 +: 32] = 32'hA5A5_1234;
        tick();
        m_ack_i = '0;
        chk("rd_ack", 32'(s_ack_o), 32'd1);
        chk("rd_err", 32'(s_err_o), 32'd0);
        chk("rd_dat", s_dat_o, 32'hA5A5_1234);
        chk("rd_stb_low", 32'(m_stb_o), 32'd0);
        chk("rd_cs_low", 32'(m_cs_o), 32'd0);
        tick();
        chk("rd_hold", 32'(s_ack_o), 32'd1);
        drop();
        tick();
        chk("rd_ack_clr", 32'(s_ack_o), 32'd0);
        chk("rd_dat_clr", s_dat_o, 32'd0);

        // write slot 0
        req(32'hFD00_0004, 1'b1, 4'b0011, 32'hDEAD_BEEF);
        tick();
        chk("wr_cs", 32'(m_cs_o), 32'h01);
        chk("wr_we", 32'(m_we_o), 32'd1);
        chk("wr_sel", 32'(m_sel_o), 32'h3);
        chk("wr_dat", m_dat_o, 32'hDEAD_BEEF);
        m_ack_i = 8'h01;
        tick();
        m_ack_i = '0;
        chk("wr_ack", 32'(s_ack_o), 32'd1);
        chk("wr_err", 32'(s_err_o), 32'd0);
        drop();
        tick();
        chk("wr_idle_sel_held", 32'(m_sel_o), 32'h3);
        chk("wr_idle_cs", 32'(m_cs_o), 32'd0);

        // unmapped: bit 19 set
        req(32'hFD08_0000, 1'b0, 4'hF, 32'h0);
        tick();
        chk("um_ack", 32'(s_ack_o), 32'd1);
        chk("um_err", 32'(s_err_o), 32'd1);
        chk("um_dat", s_dat_o, 32'hFFFF_FFFF);
        chk("um_stb", 32'(m_stb_o), 32'd0);
        chk("um_errcnt", 32'(err_cnt_o), 32'd1);
        drop();
        tick();

        // timeout on slot 5 with a spurious ack from slot 2
        req(32'hFD05_0000, 1'b0, 4'hF, 32'h0);
        tick();
        chk("to_cs", 32'(m_cs_o), 32'h20);
        m_ack_i = 8'h04;
        for (int i = 1; i <= 4; i++) begin
            tick();
            m_ack_i = '0;
            chk("to_wait_ack", 32'(s_ack_o), 32'd0);
        end
        tick();
        chk("to_ack", 32'(s_ack_o), 32'd1);
        chk("to_err", 32'(s_err_o), 32'd1);
        chk("to_stb", 32'(m_stb_o), 32'd0);
        chk("to_cyc", 32'(m_cyc_o), 32'd0);
        chk("to_errcnt", 32'(err_cnt_o), 32'd2);
        drop();
        tick();

        // abort at the second ACCESS cycle
        req(32'hFD01_0000, 1'b0, 4'hF, 32'h0);
        tick();
        tick();
        drop();
        tick();
        chk("ab_cyc", 32'(m_cyc_o), 32'd0);
        chk("ab_stb", 32'(m_stb_o), 32'd0);
        chk("ab_cs", 32'(m_cs_o), 32'd0);
        chk("ab_ack", 32'(s_ack_o), 32'd0);
        tick();
        chk("ab_ack_later", 32'(s_ack_o), 32'd0);

        // ack on the same edge the timeout would fire: ack wins
        req(32'hFD02_0000, 1'b0, 4'hF, 32'h0);
        m_dat_i[2*32 +: 32] = 32'h2222_3333;
        tick();
        for (int i = 1; i <= 4; i++) tick();
        m_ack_i = 8'h04;
        tick();
        m_ack_i = '0;
        chk("race_ack", 32'(s_ack_o), 32'd1);
        chk("race_err", 32'(s_err_o), 32'd0);
        chk("race_dat", s_dat_o, 32'h2222_3333);
        chk("race_errcnt", 32'(err_cnt_o), 32'd2);
        drop();
        tick();

        // async reset mid-ACCESS
        req(32'hFD04_0000, 1'b0, 4'hF, 32'h0);
        tick();
        chk("ar_stb_pre", 32'(m_stb_o), 32'd1);
        #2 rst_i = 1'b1;
        #1;
        chk("ar_stb", 32'(m_stb_o), 32'd0);
        chk("ar_cs", 32'(m_cs_o), 32'd0);
        chk("ar_errcnt", 32'(err_cnt_o), 32'd0);
        drop();
        #1 rst_i = 1'b0;
        tick();

        // async reset during RESP
        req(32'hFD0F_0000, 1'b0, 4'hF, 32'h0);
        tick();
        chk("rr_ack_pre", 32'(s_ack_o), 32'd1);
        #2 rst_i = 1'b1;
        #1;
        chk("rr_ack", 32'(s_ack_o), 32'd0);
        chk("rr_err", 32'(s_err_o), 32'd0);
        chk("rr_dat", s_dat_o, 32'd0);
        drop();
        #1 rst_i = 1'b0;
        tick();

        // 256 unmapped accesses saturate the error counter
        for (int i = 0; i < 256; i++) begin
            req(32'hFD0F_0000, 1'b0, 4'hF, 32'h0);
            tick();
            drop();
            tick();
            if (i == 254) chk("sat_255", 32'(err_cnt_o), 32'd255);
        end
        chk("sat_hold", 32'(err_cnt_o), 32'd255);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
